// File: rtl/agc_timer_pkg.sv
// Shared STOPMODE encodings and counter-width helpers for the AGC timepulse generator.
package agc_timer_pkg;

  localparam logic [1:0] SM_RUN      = 2'b00;
  localparam logic [1:0] SM_INST     = 2'b01;
  localparam logic [1:0] SM_PULSE    = 2'b10;
  localparam logic [1:0] SM_INST_ALT = 2'b11;

  // Counter width for a range of n values; a range of one still needs one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic stop_hit(input logic [1:0] sm, input logic last_tp);
    logic hit;
    case (sm)
      SM_PULSE:             hit = 1'b1;
      SM_INST, SM_INST_ALT: hit = last_tp;
      default:              hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/agc_clkdiv.sv
// CLOCK-to-phase divider: counts 0..DIVIDE-1 and pulses adv on the wrap.
module agc_clkdiv
  import agc_timer_pkg::*;
#(
  parameter int DIVIDE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic adv,
  output logic last_nxt
);

  localparam int            DW       = cnt_w(DIVIDE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDE - 1);

  logic [DW-1:0] div_d;
  logic [DW-1:0] div_q;

  // Next divider count; last_nxt lets the parent predict a stop boundary one cycle ahead.
  always_comb begin
    div_d = div_q;
    adv   = 1'b0;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        adv   = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d = div_q;
    end
    last_nxt = (div_d == DIV_LAST);
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC timepulse generator: phase/timepulse counters, memory-cycle parity,
// instruction/pulse stop modes with STEP advance, and GOJAM restart.
module agc_timepulse_gen
  import agc_timer_pkg::*;
#(
  parameter int NPULSES = 12,
  parameter int NPHASES = 4,
  parameter int DIVIDE  = 2
) (
  input  logic               CLOCK,
  input  logic               RESET_,
  input  logic               GOJAM,
  input  logic [1:0]         STOPMODE,
  input  logic               STEP,
  output logic [NPHASES-1:0] PHS,
  output logic [NPULSES-1:0] T,
  output logic [NPULSES-1:0] T_,
  output logic               TSTB,
  output logic               EVEN,
  output logic               STOPPED
);

  localparam int            PW      = cnt_w(NPHASES);
  localparam int            TW      = cnt_w(NPULSES);
  localparam logic [PW-1:0] PH_LAST = PW'(NPHASES - 1);
  localparam logic [TW-1:0] TP_LAST = TW'(NPULSES - 1);

  logic [PW-1:0] ph_d, ph_q;
  logic [TW-1:0] tp_d, tp_q;
  logic          even_d, even_q;
  logic          stopped_d, stopped_q;
  logic          tstb_d, tstb_q;
  logic          step_d, step_q;
  logic          step_edge_d, step_edge_q;
  logic          run;
  logic          adv;
  logic          div_last_nxt;

  // A frozen generator is released by a registered STEP edge or by returning to run mode.
  assign run = !stopped_q || step_edge_q || (STOPMODE == SM_RUN);

  agc_clkdiv #(
    .DIVIDE (DIVIDE)
  ) u_clkdiv (
    .clk      (CLOCK),
    .rst_n    (RESET_),
    .clr      (GOJAM),
    .en       (run),
    .adv      (adv),
    .last_nxt (div_last_nxt)
  );

  // Next-state for counters, parity, strobe, stop flag and STEP edge detect.
  always_comb begin
    ph_d        = ph_q;
    tp_d        = tp_q;
    even_d      = even_q;
    tstb_d      = 1'b0;
    stopped_d   = stopped_q;
    step_d      = STEP;
    step_edge_d = 1'b0;
    if (GOJAM) begin
      ph_d      = '0;
      tp_d      = '0;
      even_d    = 1'b0;
      stopped_d = 1'b0;
    end else begin
      step_edge_d = STEP & ~step_q;
      if (adv) begin
        if (ph_q == PH_LAST) begin
          ph_d   = '0;
          tstb_d = 1'b1;
          if (tp_q == TP_LAST) begin
            tp_d   = '0;
            even_d = ~even_q;
          end else begin
            tp_d = tp_q + TW'(1);
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end else begin
        ph_d = ph_q;
      end
      // STOPPED is set on entry to the boundary state, so it is looked up from the next counts.
      if (run) begin
        stopped_d = div_last_nxt && (ph_d == PH_LAST) && stop_hit(STOPMODE, tp_d == TP_LAST);
      end else begin
        stopped_d = stopped_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLOCK or negedge RESET_) begin
    if (!RESET_) begin
      ph_q        <= '0;
      tp_q        <= '0;
      even_q      <= 1'b0;
      stopped_q   <= 1'b0;
      tstb_q      <= 1'b0;
      step_q      <= 1'b0;
      step_edge_q <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      tp_q        <= tp_d;
      even_q      <= even_d;
      stopped_q   <= stopped_d;
      tstb_q      <= tstb_d;
      step_q      <= step_d;
      step_edge_q <= step_edge_d;
    end
  end

  // One-hot decode of the phase and timepulse registers.
  always_comb begin
    PHS = '0;
    T   = '0;
    for (int i = 0; i < NPHASES; i++) begin
      PHS[i] = (ph_q == PW'(i));
    end
    for (int i = 0; i < NPULSES; i++) begin
      T[i] = (tp_q == TW'(i));
    end
  end

  assign T_      = ~T;
  assign TSTB    = tstb_q;
  assign EVEN    = even_q;
  assign STOPPED = stopped_q;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Bench for agc_timepulse_gen: default and (10,2,1) instances against a linear-position model.
module tb_agc_timepulse_gen;

  localparam int N0 = 12, P0 = 4, D0 = 2;
  localparam int N1 = 10, P1 = 2, D1 = 1;

  logic       CLOCK = 1'b0;
  logic       RESET_ = 1'b0;
  logic       GOJAM = 1'b0;
  logic       STEP = 1'b0;
  logic [1:0] STOPMODE = 2'b00;

  logic [P0-1:0] phs0;
  logic [N0-1:0] t0, tn0;
  logic          tstb0, even0, stopped0;
  logic [P1-1:0] phs1;
  logic [N1-1:0] t1, tn1;
  logic          tstb1, even1, stopped1;

  agc_timepulse_gen #(.NPULSES(N0), .NPHASES(P0), .DIVIDE(D0)) dut0 (
    .CLOCK(CLOCK), .RESET_(RESET_), .GOJAM(GOJAM), .STOPMODE(STOPMODE), .STEP(STEP),
    .PHS(phs0), .T(t0), .T_(tn0), .TSTB(tstb0), .EVEN(even0), .STOPPED(stopped0));

  agc_timepulse_gen #(.NPULSES(N1), .NPHASES(P1), .DIVIDE(D1)) dut1 (
    .CLOCK(CLOCK), .RESET_(RESET_), .GOJAM(GOJAM), .STOPMODE(STOPMODE), .STEP(STEP),
    .PHS(phs1), .T(t1), .T_(tn1), .TSTB(tstb1), .EVEN(even1), .STOPPED(stopped1));

  always #5 CLOCK = ~CLOCK;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   pos [2] = '{0, 0};
  logic ev  [2] = '{1'b0, 1'b0};
  logic stp [2] = '{1'b0, 1'b0};
  logic tsb [2] = '{1'b0, 1'b0};
  logic sprev = 1'b0;
  logic sedge = 1'b0;

  function automatic int npul(input int i); return (i == 0) ? N0 : N1; endfunction
  function automatic int nph(input int i);  return (i == 0) ? P0 : P1; endfunction
  function automatic int dvd(input int i);  return (i == 0) ? D0 : D1; endfunction
  function automatic int tlen(input int i); return nph(i) * dvd(i); endfunction
  function automatic int mlen(input int i); return npul(i) * tlen(i); endfunction

  function automatic logic [11:0] exp_t(input int i);
    logic [11:0] v;
    v = 12'd1;
    return v << (pos[i] / tlen(i));
  endfunction

  function automatic logic [3:0] exp_phs(input int i);
    logic [3:0] v;
    v = 4'd1;
    return v << ((pos[i] / dvd(i)) % nph(i));
  endfunction

  function automatic logic will_stop(input int i, input int p, input logic [1:0] sm);
    if (p % tlen(i) != tlen(i) - 1) return 1'b0;
    if (sm == 2'b10) return 1'b1;
    return sm[0] && (p / tlen(i) == npul(i) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: position within the memory cycle plus parity, stop flag and strobe.
  always @(posedge CLOCK or negedge RESET_) begin
    if (!RESET_) begin
      cyc   <= 0;
      sprev <= 1'b0;
      sedge <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pos[i] <= 0; ev[i] <= 1'b0; stp[i] <= 1'b0; tsb[i] <= 1'b0;
      end
    end else begin
      cyc   <= cyc + 1;
      sedge <= !GOJAM && STEP && !sprev;
      sprev <= STEP;
      for (int i = 0; i < 2; i++) begin
        if (GOJAM) begin
          pos[i] <= 0; ev[i] <= 1'b0; stp[i] <= 1'b0; tsb[i] <= 1'b0;
        end else if (stp[i] && !sedge && STOPMODE != 2'b00) begin
          tsb[i] <= 1'b0;
        end else begin
          pos[i] <= (pos[i] + 1) % mlen(i);
          ev[i]  <= ev[i] ^ ((pos[i] + 1) == mlen(i));
          tsb[i] <= ((pos[i] + 1) % tlen(i)) == 0;
          stp[i] <= will_stop(i, (pos[i] + 1) % mlen(i), STOPMODE);
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLOCK) begin
    check("outs0", {13'b0, t0, phs0, tstb0, even0, stopped0},
                   {13'b0, exp_t(0), exp_phs(0), tsb[0], ev[0], stp[0]});
    check("outs1", {15'b0, t1, 2'b0, phs1, tstb1, even1, stopped1},
                   {13'b0, exp_t(1), exp_phs(1), tsb[1], ev[1], stp[1]});
    check("tn0", {20'b0, tn0 ^ t0}, 32'h00000FFF);
    check("tn1", {22'b0, tn1 ^ t1}, 32'h000003FF);
    check("onehot", {31'b0, $onehot(t0) && $onehot(phs0) && $onehot(t1) && $onehot(phs1)}, 32'd1);
  end

  task automatic wait_to(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 5000) begin
      @(negedge CLOCK);
      guard++;
    end
    check("wait_to", cyc, k);
  endtask

  task automatic do_reset(input logic [1:0] sm);
    @(negedge CLOCK);
    RESET_ = 1'b0; GOJAM = 1'b0; STEP = 1'b0; STOPMODE = sm;
    repeat (2) @(negedge CLOCK);
    RESET_ = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge CLOCK);
    check("rst_T", {20'b0, t0}, 32'h001);
    check("rst_Tn", {20'b0, tn0}, 32'hFFE);
    check("rst_PHS", {28'b0, phs0}, 32'h1);
    check("rst_flags", {29'b0, tstb0, even0, stopped0}, 32'h0);
    RESET_ = 1'b1;

    // Free run with defaults
    wait_to(7);   check("c7_T", {20'b0, t0}, 32'h001);
    wait_to(8);   check("c8_T", {20'b0, t0}, 32'h002);  check("c8_TSTB", {31'b0, tstb0}, 32'd1);
    check("c8_model", {20'b0, exp_t(0)}, 32'h002);
    wait_to(9);   check("c9_PHS", {28'b0, phs0}, 32'h1); check("c9_TSTB", {31'b0, tstb0}, 32'd0);
    wait_to(10);  check("c10_PHS", {28'b0, phs0}, 32'h2);
    wait_to(20);  check("i1_c20_EVEN", {31'b0, even1}, 32'd1); check("i1_c20_T", {22'b0, t1}, 32'h001);
    wait_to(95);  check("c95_T", {20'b0, t0}, 32'h800); check("c95_EVEN", {31'b0, even0}, 32'd0);
    wait_to(96);  check("c96", {20'b0, t0, tstb0, even0}, {20'b0, 12'h001, 2'b11});
    check("c96_model", {31'b0, ev[0]}, 32'd1);

    // Instruction stop
    do_reset(2'b01);
    wait_to(19);  check("i1_stop19", {31'b0, stopped1}, 32'd1);
    wait_to(94);  check("s01_c94", {31'b0, stopped0}, 32'd0);
    wait_to(95);  check("s01_c95", {20'b0, t0, phs0, stopped0}, {20'b0, 12'h800, 4'h8, 1'b1});
    wait_to(120); check("s01_c120", {20'b0, t0, stopped0}, {20'b0, 12'h800, 1'b1});
    STEP = 1'b1;
    wait_to(121); STEP = 1'b0;
    check("s01_c121", {20'b0, t0}, 32'h800);
    wait_to(122); check("s01_c122", {20'b0, t0, tstb0, even0, stopped0}, {20'b0, 12'h001, 3'b110});
    wait_to(217); check("s01_c217", {20'b0, t0, stopped0}, {20'b0, 12'h800, 1'b1});

    // Pulse stop with three steps, then resume
    do_reset(2'b10);
    wait_to(7);   check("s10_c7", {20'b0, t0, phs0, stopped0}, {20'b0, 12'h001, 4'h8, 1'b1});
    for (int k = 0; k < 3; k++) begin
      wait_to(10 + 20 * k); STEP = 1'b1;
      wait_to(11 + 20 * k); STEP = 1'b0;
      wait_to(12 + 20 * k);
      check("s10_step", {20'b0, t0, tstb0}, {19'b0, 12'h002 << k, 1'b1});
      wait_to(19 + 20 * k);
      check("s10_stop", {20'b0, t0, phs0, stopped0}, {15'b0, 12'h002 << k, 4'h8, 1'b1});
    end
    wait_to(70);  STOPMODE = 2'b00;
    wait_to(71);  check("s10_resume", {20'b0, t0, tstb0, stopped0}, {20'b0, 12'h010, 2'b10});

    // GOJAM during T07/PHS2 of the second memory cycle
    do_reset(2'b00);
    wait_to(146); check("gj_pre", {20'b0, t0, phs0, even0}, {20'b0, 12'h040, 4'h2, 1'b1});
    GOJAM = 1'b1;
    for (int c = 147; c <= 151; c++) begin
      wait_to(c);
      check("gj_hold", {20'b0, t0, phs0, tstb0, even0, stopped0}, {20'b0, 12'h001, 4'h1, 3'b000});
    end
    GOJAM = 1'b0;
    wait_to(152); check("gj_rel", {20'b0, t0, phs0, tstb0}, {20'b0, 12'h001, 4'h1, 1'b0});
    wait_to(153); check("gj_rel_phs", {28'b0, phs0}, 32'h2);
    wait_to(159); check("gj_t02", {20'b0, t0, tstb0}, {19'b0, 12'h002, 1'b1});

    // GOJAM coincident with a STEP edge while stopped
    do_reset(2'b10);
    wait_to(9);   STEP = 1'b1; GOJAM = 1'b1;
    wait_to(10);  STEP = 1'b0; GOJAM = 1'b0;
    check("gjs_c10", {20'b0, t0, phs0, tstb0, stopped0}, {20'b0, 12'h001, 4'h1, 2'b00});
    wait_to(17);  check("gjs_c17", {20'b0, t0, stopped0}, {20'b0, 12'h001, 1'b1});

    // Asynchronous reset mid-run at T09
    do_reset(2'b00);
    wait_to(67);  check("ar_pre", {20'b0, t0}, 32'h100);
    #2 RESET_ = 1'b0;
    #1 check("ar_async", {20'b0, t0, phs0, tstb0, even0, stopped0}, {20'b0, 12'h001, 4'h1, 3'b000});
    @(negedge CLOCK); RESET_ = 1'b1;
    wait_to(10);  check("ar_resume", {20'b0, t0}, 32'h002);

    // Randomized traffic
    do_reset(2'b00);
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLOCK);
      STEP  = ($urandom_range(0, 7) == 0);
      GOJAM = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) STOPMODE = 2'($urandom_range(0, 3));
    end
    @(negedge CLOCK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/agc_timepulse_gen.md
# agc_timepulse_gen

Parametrised timepulse generator for the AGC datapath. It divides the master CLOCK into per-timepulse phases and one-hot timepulses T01..Tn, and tracks odd/even memory cycles. It also provides instruction-step and pulse-step stop modes with a manual STEP advance, plus a synchronous GOJAM restart. It sits beside the existing timer and is the generalised generator that the control-pulse matrix and memory-cycle logic consume.

## Interface
- NPULSES, 12: timepulses per memory cycle (≥2)
- NPHASES, 4: phases per timepulse (≥1)
- DIVIDE, 2: CLOCK cycles per phase (≥1)

- CLOCK  in  1  master clock, all state on rising edge
- RESET_  in  1  asynchronous, active-low reset
- GOJAM  in  1  synchronous restart, level-sensitive
- STOPMODE  in  2  00 run, 01 stop at end of last timepulse, 10 stop at end of every timepulse, 11 same as 01
- STEP  in  1  advance one boundary while stopped; rising-edge detected internally
- PHS  out  NPHASES  one-hot current phase, bit 0 = PHS1
- T  out  NPULSES  one-hot current timepulse, bit 0 = T01
- T_  out  NPULSES  bitwise complement of T
- TSTB  out  1  high for the first CLOCK cycle of a timepulse entered by advance or step
- EVEN  out  1  memory-cycle parity; toggles on every wrap Tn→T01
- STOPPED  out  1  generator frozen at a stop boundary

## Operation
- Counters: div_cnt 0..DIVIDE-1, ph 0..NPHASES-1, tp 0..NPULSES-1. All are registered. PHS, T and T_ decode from registers.
- Each cycle div_cnt increments. At DIVIDE-1 it wraps and ph advances. On the ph wrap, tp advances (a "boundary"). On the tp wrap from NPULSES-1, EVEN toggles.
- Stop check at a boundary: the stop condition is STOPMODE=10, or STOPMODE∈{01,11} with tp=NPULSES-1. If it holds, counters freeze at div_cnt=DIVIDE-1, ph=NPHASES-1, tp unchanged, and STOPPED←1.
- While stopped, a STEP rising edge (registered, one-cycle) performs the pending boundary advance. STOPPED←0, TSTB←1. Counting then continues to the next stop boundary.
- A STOPMODE change to 00 while stopped resumes the pending advance on the next cycle, as if stepped.
- A STEP edge while running is ignored.
- GOJAM has highest priority:
  - next state is div_cnt=0, ph=0, tp=0, EVEN=0, STOPPED=0, TSTB=0
  - the state is held while GOJAM stays high
  - counting resumes the cycle after GOJAM falls
- Coincident GOJAM and STEP: GOJAM wins. The STEP edge is discarded.

## Timing
- Reset values: PHS=1 (PHS1), T=1 (T01), T_=~1, TSTB=0, EVEN=0, STOPPED=0, STEP edge register 0.
- Timepulse period is NPHASES·DIVIDE cycles. Memory cycle is NPULSES·NPHASES·DIVIDE cycles; the default is 96.
- Latency: a boundary advance is visible on T the cycle after div_cnt=DIVIDE-1 in the last phase. A STEP edge affects T 2 cycles after the STEP input rises (1 for edge detect, 1 for advance).
- STOPPED rises in the same cycle the frozen state is entered, i.e. when the stop boundary would otherwise have advanced.
- TSTB is never asserted by reset or GOJAM release.
- An async reset mid-step or mid-stop returns to the reset values immediately.

## Structure
- Shared package agc_timer_pkg holds:
  - STOPMODE encoding constants (SM_RUN, SM_INST, SM_PULSE)
  - a width helper based on $clog2 for the counter sizes
- Sub-module agc_clkdiv contains the DIVIDE counter. It emits a one-cycle phase-advance enable and honours the freeze/clear controls.
- The top-level contains the phase/timepulse counters, stop logic, STEP edge detect and output decode.

## Test plan
- Defaults, STOPMODE=00 after reset: T01 cycles 0–7, T02 from cycle 8, PHS cycles every 2 cycles. T12 ends at cycle 95, EVEN=1 from cycle 96, and TSTB fires at cycles 8, 16, …, 96.
- Instance NPULSES=10, NPHASES=2, DIVIDE=1: timepulse period is 2 and memory cycle 20. T_ is always ~T and T/PHS are always one-hot.
- STOPMODE=01: freeze at T12/PHS4 with STOPPED=1 at cycle 95. A STEP pulse at cycle 120 gives T01 at cycle 122 with TSTB=1 and EVEN toggled; the generator then stops again at the next T12 end.
- STOPMODE=10: stops after every timepulse. Three STEP pulses advance T01→T04, each stop showing STOPPED=1 at PHS-last. Switching to 00 resumes the next cycle.
- GOJAM for 5 cycles during T07/PHS2: T01/PHS1, EVEN=0, STOPPED=0 throughout. Counting restarts the cycle after release with no TSTB. GOJAM coincident with a STEP edge while stopped also results in T01, not a step.
- RESET_ asserted mid-run at T09: all outputs take their reset values asynchronously, and running resumes from T01 after release.
